fft_frame_buf: RTL and testbench

//  Sink for the FIR output stream. Collects consecutive fir_d samples into
//  N_PT-sample frames in a two-bank ping-pong buffer.

---
 rtl/fft_frame_buf_if.sv | 33 +++
 rtl/fft_frame_buf.sv | 190 +++++++++++++++++++
 tb/tb_fft_frame_buf.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_buf_if.sv
// Bus bundle between the FIR sink side, the frame buffer and the FFT stage.
//
// Handshake rules:
//   fir_valid is a one-way strobe with no back-pressure. The FIR cannot stall,
//   so every cycle with fir_valid=1 carries a new sample in fir_d.
//   frame_valid/frame_ready is a strict valid/ready pair. A transfer happens
//   at a rising edge where both are 1. Once frame_valid rises, it and frame_d
//   hold until that transfer. frame_ready may be driven freely and is ignored
//   while frame_valid=0.
interface fft_frame_buf_if #(
  parameter int DW   = 16,
  parameter int N_PT = 16
);
  logic                 fir_valid;
  logic [DW-1:0]        fir_d;
  logic                 frame_ready;
  logic                 frame_valid;
  logic [DW*N_PT-1:0]   frame_d;
  logic                 frame_ovf;
  logic [7:0]           drop_cnt;
  // Writer FSM state, exposed for checkers (0 idle, 1 write, 2 discard)
  logic [1:0]           dbg_wr_state;

  modport master (
    output fir_valid, fir_d, frame_ready,
    input  frame_valid, frame_d, frame_ovf, drop_cnt, dbg_wr_state
  );

  modport slave (
    input  fir_valid, fir_d, frame_ready,
    output frame_valid, frame_d, frame_ovf, drop_cnt, dbg_wr_state
  );
endinterface

// File: rtl/fft_frame_buf.sv
// Ping-pong frame collector between the FIR output and the FFT input.
// Consecutive samples are packed into N_PT-sample frames across two register
// banks. Complete frames are offered in parallel and in capture order. A frame
// that starts while no bank is free is discarded whole and counted.
module fft_frame_buf #(
  parameter int DW   = 16,
  parameter int N_PT = 16
) (
  input  logic clk,
  input  logic rst,
  fft_frame_buf_if.slave bus
);

  localparam int CW = (N_PT > 1) ? $clog2(N_PT) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_PT - 1);

  typedef enum logic [1:0] {
    B_EMPTY   = 2'd0,
    B_FILLING = 2'd1,
    B_FULL    = 2'd2
  } bank_t;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_WRITE   = 2'd1,
    W_DISCARD = 2'd2
  } wr_state_t;

  // Registered state
  bank_t          bank_st [2];
  logic [DW-1:0]  mem [2][N_PT];
  logic           wr_bank;
  logic           rd_bank;
  logic [CW-1:0]  wr_cnt;
  wr_state_t      wr_st;
  logic [7:0]     drop_q;
  logic           ovf_q;
  logic           fv_q;

  // Next-state values
  bank_t          bank_st_n [2];
  logic           wr_bank_n;
  logic           rd_bank_n;
  logic [CW-1:0]  wr_cnt_n;
  wr_state_t      wr_st_n;
  logic [7:0]     drop_n;
  logic           ovf_n;
  logic           fv_n;

  // Sample write port into the bank storage
  logic           mem_we;
  logic [CW-1:0]  mem_idx;

  logic           xfer;
  logic           wr_last;
  logic           wr_free;

  // fv_q always mirrors "read bank is FULL", so it alone qualifies a transfer
  assign xfer    = fv_q & bus.frame_ready;
  assign wr_last = (wr_cnt == LAST_IDX);
  // The write bank may start a new frame if it is empty, or if it holds the
  // frame being handed to the FFT at this very edge (handshake bypass).
  assign wr_free = (bank_st[wr_bank] == B_EMPTY) ||
                   ((bank_st[wr_bank] == B_FULL) && xfer && (rd_bank == wr_bank));

  // Next-state logic for the reader, the bank states and the writer FSM
  always_comb begin
    bank_st_n = bank_st;
    rd_bank_n = rd_bank;
    wr_bank_n = wr_bank;
    wr_cnt_n  = wr_cnt;
    wr_st_n   = wr_st;
    drop_n    = drop_q;
    ovf_n     = ovf_q;
    mem_we    = 1'b0;
    mem_idx   = wr_cnt;

    // Reader: a transfer frees the read bank and advances to the other one
    if (xfer) begin
      bank_st_n[rd_bank] = B_EMPTY;
      rd_bank_n          = ~rd_bank;
    end

    // Writer: later assignments override the reader's, which is what lets a
    // freshly consumed bank go straight to FILLING in the bypass case
    case (wr_st)
      W_IDLE: begin
        if (bus.fir_valid) begin
          wr_cnt_n = CW'(1);
          if (wr_free) begin
            mem_we             = 1'b1;
            mem_idx            = '0;
            bank_st_n[wr_bank] = B_FILLING;
            wr_st_n            = W_WRITE;
          end else begin
            wr_st_n = W_DISCARD;
          end
        end
      end

      W_WRITE: begin
        if (bus.fir_valid) begin
          mem_we   = 1'b1;
          mem_idx  = wr_cnt;
          wr_cnt_n = wr_cnt + CW'(1);
          if (wr_last) begin
            bank_st_n[wr_bank] = B_FULL;
            wr_bank_n          = ~wr_bank;
            wr_st_n            = W_IDLE;
          end
        end else begin
          // Gap in the stream: the partial frame is abandoned, not dropped
          bank_st_n[wr_bank] = B_EMPTY;
          wr_cnt_n           = '0;
          wr_st_n            = W_IDLE;
        end
      end

      W_DISCARD: begin
        if (bus.fir_valid) begin
          wr_cnt_n = wr_cnt + CW'(1);
          if (wr_last) begin
            if (drop_q != 8'hFF) begin
              drop_n = drop_q + 8'd1;
            end
            ovf_n   = 1'b1;
            wr_st_n = W_IDLE;
          end
        end else begin
          wr_cnt_n = '0;
          wr_st_n  = W_IDLE;
        end
      end

      default: begin
        wr_st_n = W_IDLE;
      end
    endcase

    fv_n = (bank_st_n[rd_bank_n] == B_FULL);
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      wr_st      <= W_IDLE;
      drop_q     <= 8'd0;
      ovf_q      <= 1'b0;
      fv_q       <= 1'b0;
    end else begin
      bank_st    <= bank_st_n;
      wr_bank    <= wr_bank_n;
      rd_bank    <= rd_bank_n;
      wr_cnt     <= wr_cnt_n;
      wr_st      <= wr_st_n;
      drop_q     <= drop_n;
      ovf_q      <= ovf_n;
      fv_q       <= fv_n;
    end
  end

  // Sample storage; cleared on reset so frame_d reads as zero afterwards
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N_PT; k++) begin
          mem[b][k] <= '0;
        end
      end
    end else if (mem_we) begin
      mem[wr_bank][mem_idx] <= bus.fir_d;
    end
  end

  // Present the read bank in parallel, oldest sample in the low slice
  for (genvar k = 0; k < N_PT; k++) begin : g_frame
    assign bus.frame_d[DW*k +: DW] = mem[rd_bank][k];
  end

  assign bus.frame_valid  = fv_q;
  assign bus.frame_ovf    = ovf_q;
  assign bus.drop_cnt     = drop_q;
  assign bus.dbg_wr_state = wr_st;

endmodule

// File: tb/tb_fft_frame_buf.sv
// Directed bench for fft_frame_buf: reset, single frame, overflow, handshake
// bypass, back-to-back streaming, abandoned partial frame, mid-frame reset
// and drop counter saturation.
module tb_fft_frame_buf;

  localparam int DW   = 16;
  localparam int N_PT = 16;
  localparam int FW   = DW * N_PT;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_frame_buf_if #(.DW(DW), .N_PT(N_PT)) bus ();

  fft_frame_buf #(.DW(DW), .N_PT(N_PT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Scoreboard
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] got_q[$];
  int checks = 0;
  int errors = 0;

  // Frame holding samples base, base+1, ... base+N_PT-1
  function automatic logic [FW-1:0] mk_frame(input int base);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < N_PT; k++) begin
      f[DW*k +: DW] = DW'(base + k);
    end
    return f;
  endfunction

  // One clock: present inputs, log any frame accepted at the coming edge,
  // then return 1 time unit after that edge with outputs settled.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    bus.fir_valid   = v;
    bus.fir_d       = d;
    bus.frame_ready = r;
    if (bus.frame_valid === 1'b1 && r) begin
      got_q.push_back(bus.frame_d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b0;
    repeat (n) drive(1'b0, '0, 1'b0);
    rst = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      errors++; $display("FAIL reset_frame_valid got %b exp 0", bus.frame_valid);
    end
    checks++;
    if (bus.frame_d !== '0) begin
      errors++; $display("FAIL reset_frame_d got %h exp 0", bus.frame_d);
    end
    checks++;
    if (bus.frame_ovf !== 1'b0) begin
      errors++; $display("FAIL reset_frame_ovf got %b exp 0", bus.frame_ovf);
    end
    checks++;
    if (bus.drop_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_drop_cnt got %0d exp 0", bus.drop_cnt);
    end
    rst = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_single_frame();
    for (int i = 0; i < 16; i++) drive(1'b1, DW'(i), 1'b1);
    checks++;
    if (bus.frame_valid !== 1'b1) begin
      errors++; $display("FAIL single_valid_rise got %b exp 1", bus.frame_valid);
    end
    checks++;
    if (bus.frame_d[15:0] !== 16'd0) begin
      errors++; $display("FAIL single_sample0 got %0d exp 0", bus.frame_d[15:0]);
    end
    checks++;
    if (bus.frame_d[255:240] !== 16'd15) begin
      errors++; $display("FAIL single_sample15 got %0d exp 15", bus.frame_d[255:240]);
    end
    drive(1'b0, '0, 1'b1);
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      errors++; $display("FAIL single_valid_fall got %b exp 0", bus.frame_valid);
    end
    exp_q.push_back(mk_frame(0));
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL single_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL single_frame%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    apply_reset(1);
    for (int i = 0; i < 48; i++) drive(1'b1, DW'(i), 1'b0);
    checks++;
    if (bus.drop_cnt !== 8'd1) begin
      errors++; $display("FAIL ovf_drop_cnt got %0d exp 1", bus.drop_cnt);
    end
    checks++;
    if (bus.frame_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_flag got %b exp 1", bus.frame_ovf);
    end
    repeat (3) drive(1'b0, '0, 1'b1);
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_drained_valid got %b exp 0", bus.frame_valid);
    end
    exp_q.push_back(mk_frame(0));
    exp_q.push_back(mk_frame(16));
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ovf_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ovf_frame%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_bypass();
    apply_reset(1);
    for (int i = 0; i < 32; i++) drive(1'b1, DW'(i), 1'b0);
    drive(1'b1, DW'(32), 1'b1);
    checks++;
    if (bus.frame_valid !== 1'b1) begin
      errors++; $display("FAIL bypass_second_valid got %b exp 1", bus.frame_valid);
    end
    for (int i = 33; i < 48; i++) drive(1'b1, DW'(i), 1'b1);
    repeat (2) drive(1'b0, '0, 1'b1);
    checks++;
    if (bus.drop_cnt !== 8'd0) begin
      errors++; $display("FAIL bypass_drop_cnt got %0d exp 0", bus.drop_cnt);
    end
    checks++;
    if (bus.frame_ovf !== 1'b0) begin
      errors++; $display("FAIL bypass_ovf got %b exp 0", bus.frame_ovf);
    end
    exp_q.push_back(mk_frame(0));
    exp_q.push_back(mk_frame(16));
    exp_q.push_back(mk_frame(32));
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bypass_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bypass_frame%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset(1);
    for (int i = 0; i < 64; i++) drive(1'b1, DW'(300 + i), 1'b1);
    repeat (2) drive(1'b0, '0, 1'b1);
    checks++;
    if (bus.drop_cnt !== 8'd0) begin
      errors++; $display("FAIL b2b_drop_cnt got %0d exp 0", bus.drop_cnt);
    end
    for (int f = 0; f < 4; f++) exp_q.push_back(mk_frame(300 + 16 * f));
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_frame%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abandon();
    apply_reset(1);
    for (int i = 0; i < 7; i++) drive(1'b1, DW'(i), 1'b1);
    repeat (3) drive(1'b0, '0, 1'b1);
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      errors++; $display("FAIL abandon_no_valid got %b exp 0", bus.frame_valid);
    end
    for (int i = 0; i < 16; i++) drive(1'b1, DW'(100 + i), 1'b1);
    repeat (2) drive(1'b0, '0, 1'b1);
    checks++;
    if (bus.drop_cnt !== 8'd0) begin
      errors++; $display("FAIL abandon_drop_cnt got %0d exp 0", bus.drop_cnt);
    end
    exp_q.push_back(mk_frame(100));
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL abandon_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL abandon_frame%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset(1);
    for (int i = 0; i < 16; i++) drive(1'b1, DW'(i), 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, DW'(200 + i), 1'b0);
    rst = 1'b0;
    drive(1'b1, DW'(205), 1'b0);
    rst = 1'b1;
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_valid got %b exp 0", bus.frame_valid);
    end
    checks++;
    if (bus.frame_d !== '0) begin
      errors++; $display("FAIL midrst_frame_d got %h exp 0", bus.frame_d);
    end
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) drive(1'b1, DW'(50 + i), 1'b0);
    checks++;
    if (bus.frame_d !== mk_frame(50)) begin
      errors++; $display("FAIL midrst_first_frame got %h exp %h", bus.frame_d, mk_frame(50));
    end
    for (int i = 0; i < 16; i++) drive(1'b1, DW'(70 + i), 1'b0);
    checks++;
    if (bus.drop_cnt !== 8'd0) begin
      errors++; $display("FAIL midrst_drop_cnt got %0d exp 0", bus.drop_cnt);
    end
    repeat (3) drive(1'b0, '0, 1'b1);
    exp_q.push_back(mk_frame(50));
    exp_q.push_back(mk_frame(70));
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midrst_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL midrst_frame%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_drop_saturate();
    apply_reset(1);
    for (int i = 0; i < 32; i++) drive(1'b1, DW'(i), 1'b0);
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 16; k++) drive(1'b1, DW'(1000 + k), 1'b0);
      if (f == 99) begin
        checks++;
        if (bus.drop_cnt !== 8'd100) begin
          errors++; $display("FAIL sat_mid_count got %0d exp 100", bus.drop_cnt);
        end
      end
    end
    checks++;
    if (bus.drop_cnt !== 8'd255) begin
      errors++; $display("FAIL sat_drop_cnt got %0d exp 255", bus.drop_cnt);
    end
    checks++;
    if (bus.frame_ovf !== 1'b1) begin
      errors++; $display("FAIL sat_ovf got %b exp 1", bus.frame_ovf);
    end
    repeat (3) drive(1'b0, '0, 1'b1);
    exp_q.push_back(mk_frame(0));
    exp_q.push_back(mk_frame(16));
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL sat_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL sat_frame%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    bus.fir_valid   = 1'b0;
    bus.fir_d       = '0;
    bus.frame_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_frame();
    test_overflow();
    test_bypass();
    test_back_to_back();
    test_abandon();
    test_mid_reset();
    test_drop_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
